// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Package  : mips_pkg
// Purpose  : Shared definitions for the ID/EX pipeline slice: datapath and
//            register-number widths, ALU function codes, and the operand
//            forward-select encoding.
// Revision : 1.0 - initial release
// ============================================================================
package mips_pkg;

   localparam int DW = 32;   // datapath width
   localparam int RW = 5;    // register-number width

   // ALU function codes (aluc)
   localparam logic [3:0] C_ALUC_ADD = 4'b0000;
   localparam logic [3:0] C_ALUC_SUB = 4'b0100;
   localparam logic [3:0] C_ALUC_AND = 4'b0001;
   localparam logic [3:0] C_ALUC_OR  = 4'b0101;
   localparam logic [3:0] C_ALUC_XOR = 4'b0010;
   localparam logic [3:0] C_ALUC_LUI = 4'b0110;
   localparam logic [3:0] C_ALUC_SLL = 4'b0011;
   localparam logic [3:0] C_ALUC_SRL = 4'b0111;
   localparam logic [3:0] C_ALUC_SRA = 4'b1111;

   // Where a source operand is taken from
   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_EX  = 2'b01,
      FWD_MEM = 2'b10,
      FWD_WB  = 2'b11
   } fwd_e;

endpackage
`default_nettype wire

// File: rtl/fwd_sel.sv
`default_nettype none
// ============================================================================
// Module   : fwd_sel
// Purpose  : Priority forwarding selector for one source operand.
//            Youngest producer wins: EX, then MEM, then WB, else the
//            register-file value. Register 0 never forwards.
// Ports    : src                   - source register number
//            rf_val                - register-file read data
//            ex_hit_en             - EX stage holds a forwardable result
//            ex_rn/ex_val          - EX destination / result
//            mem_wreg/mem_rn/mem_val - MEM write flag / destination / result
//            wb_wreg/wb_rn/wb_val  - WB write flag / destination / result
//            val                   - selected operand value
// Revision : 1.0 - initial release
// ============================================================================
module fwd_sel
   import mips_pkg::*;
#(
   parameter int DW = mips_pkg::DW,
   parameter int RW = mips_pkg::RW
) (
   input  logic [RW-1:0] src,
   input  logic [DW-1:0] rf_val,
   input  logic          ex_hit_en,
   input  logic [RW-1:0] ex_rn,
   input  logic [DW-1:0] ex_val,
   input  logic          mem_wreg,
   input  logic [RW-1:0] mem_rn,
   input  logic [DW-1:0] mem_val,
   input  logic          wb_wreg,
   input  logic [RW-1:0] wb_rn,
   input  logic [DW-1:0] wb_val,
   output logic [DW-1:0] val
);

   fwd_e w_sel;

   always_comb begin
      w_sel = FWD_RF;
      if (src != '0) begin
         if (ex_hit_en && (ex_rn == src))
            w_sel = FWD_EX;
         else if (mem_wreg && (mem_rn == src))
            w_sel = FWD_MEM;
         else if (wb_wreg && (wb_rn == src))
            w_sel = FWD_WB;
      end
   end

   always_comb begin
      case (w_sel)
         FWD_EX:  val = ex_val;
         FWD_MEM: val = mem_val;
         FWD_WB:  val = wb_val;
         default: val = rf_val;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage
// Purpose  : ID/EX pipeline register in front of the 32-bit ALU. Resolves
//            operand forwarding (EX/MEM/WB), selects immediate or shift
//            amount for operand b, detects load-use hazards and registers
//            the decoded instruction into EX.
// Build    : ID_EX_FWD_EX_EN defined   - ex_alu_r forwards into ID; only a
//                                        load in EX causes a stall.
//            ID_EX_FWD_EX_EN undefined - ex_alu_r is ignored; any dependency
//                                        on the EX instruction stalls.
// Ports    : clk, resetn (sync, active low)
//            id_*        - decoded instruction from ID
//            ex_alu_r    - current ALU result
//            mem_*/wb_*  - later-stage write-back info for forwarding
//            flush       - squash the instruction entering EX
//            ext_stall   - global freeze
//            ex_*        - registered EX-stage operands and control
//            id_stall    - combinational hazard, holds PC and IF/ID
// Revision : 1.0 - initial release
// ============================================================================
module id_ex_stage
   import mips_pkg::*;
#(
   parameter int DW = mips_pkg::DW,
   parameter int RW = mips_pkg::RW
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          id_valid,
   input  logic [RW-1:0] id_rs,
   input  logic [RW-1:0] id_rt,
   input  logic          id_use_rs,
   input  logic          id_use_rt,
   input  logic [DW-1:0] id_rs_val,
   input  logic [DW-1:0] id_rt_val,
   input  logic [DW-1:0] id_imm,
   input  logic [4:0]    id_sa,
   input  logic [3:0]    id_aluc,
   input  logic          id_aluimm,
   input  logic          id_shift,
   input  logic [RW-1:0] id_rn,
   input  logic          id_wreg,
   input  logic          id_m2reg,
   input  logic          id_wmem,
   input  logic [DW-1:0] ex_alu_r,
   input  logic          mem_wreg,
   input  logic [RW-1:0] mem_rn,
   input  logic [DW-1:0] mem_data,
   input  logic          wb_wreg,
   input  logic [RW-1:0] wb_rn,
   input  logic [DW-1:0] wb_data,
   input  logic          flush,
   input  logic          ext_stall,
   output logic [DW-1:0] ex_a,
   output logic [DW-1:0] ex_b,
   output logic [3:0]    ex_aluc,
   output logic [DW-1:0] ex_store,
   output logic          ex_valid,
   output logic          ex_wreg,
   output logic          ex_m2reg,
   output logic          ex_wmem,
   output logic [RW-1:0] ex_rn,
   output logic          id_stall
);

   logic [DW-1:0] r_ex_a;
   logic [DW-1:0] r_ex_b;
   logic [3:0]    r_ex_aluc;
   logic [DW-1:0] r_ex_store;
   logic          r_ex_valid;
   logic          r_ex_wreg;
   logic          r_ex_m2reg;
   logic          r_ex_wmem;
   logic [RW-1:0] r_ex_rn;

   logic          w_ex_fwd_ok;     // EX result may be forwarded this cycle
   logic [DW-1:0] w_ex_fwd_val;
   logic          w_ex_dep_stall;  // a dependency on EX must stall
   logic [DW-1:0] w_fwd_rs;
   logic [DW-1:0] w_fwd_rt;
   logic [DW-1:0] w_op_a;
   logic [DW-1:0] w_op_b;
   logic          w_ex_dep;
   logic          w_id_stall;

`ifdef ID_EX_FWD_EX_EN
   // A load's data is not ready until MEM, so only non-loads forward from EX.
   assign w_ex_fwd_ok    = r_ex_valid & r_ex_wreg & ~r_ex_m2reg;
   assign w_ex_fwd_val   = ex_alu_r;
   assign w_ex_dep_stall = r_ex_m2reg;
`else
   // No EX forward path: every EX dependency waits one cycle for MEM.
   logic w_unused_ex_alu_r;
   assign w_unused_ex_alu_r = ^ex_alu_r;
   assign w_ex_fwd_ok       = 1'b0;
   assign w_ex_fwd_val      = '0;
   assign w_ex_dep_stall    = 1'b1;
`endif

   fwd_sel #(.DW(DW), .RW(RW)) u_fwd_rs (
      .src       (id_rs),
      .rf_val    (id_rs_val),
      .ex_hit_en (w_ex_fwd_ok),
      .ex_rn     (r_ex_rn),
      .ex_val    (w_ex_fwd_val),
      .mem_wreg  (mem_wreg),
      .mem_rn    (mem_rn),
      .mem_val   (mem_data),
      .wb_wreg   (wb_wreg),
      .wb_rn     (wb_rn),
      .wb_val    (wb_data),
      .val       (w_fwd_rs)
   );

   fwd_sel #(.DW(DW), .RW(RW)) u_fwd_rt (
      .src       (id_rt),
      .rf_val    (id_rt_val),
      .ex_hit_en (w_ex_fwd_ok),
      .ex_rn     (r_ex_rn),
      .ex_val    (w_ex_fwd_val),
      .mem_wreg  (mem_wreg),
      .mem_rn    (mem_rn),
      .mem_val   (mem_data),
      .wb_wreg   (wb_wreg),
      .wb_rn     (wb_rn),
      .wb_val    (wb_data),
      .val       (w_fwd_rt)
   );

   // Shifts put the shifted value (rt) on a and the amount on b.
   assign w_op_a = id_shift ? w_fwd_rt : w_fwd_rs;
   assign w_op_b = id_shift  ? {{(DW-5){1'b0}}, id_sa} :
                   id_aluimm ? id_imm : w_fwd_rt;

   // Bubbles carry rn = 0, so the rn != 0 test also filters empty EX slots.
   assign w_ex_dep = ((id_use_rs & (r_ex_rn == id_rs)) |
                      (id_use_rt & (r_ex_rn == id_rt)));
   assign w_id_stall = id_valid & r_ex_valid & w_ex_dep_stall &
                       (r_ex_rn != '0) & w_ex_dep;

   always_ff @(posedge clk) begin
      if (!resetn || flush || (!ext_stall && (w_id_stall || !id_valid))) begin
         // Bubble: data fields zeroed too, so nothing downstream can match it.
         r_ex_a     <= '0;
         r_ex_b     <= '0;
         r_ex_aluc  <= '0;
         r_ex_store <= '0;
         r_ex_valid <= 1'b0;
         r_ex_wreg  <= 1'b0;
         r_ex_m2reg <= 1'b0;
         r_ex_wmem  <= 1'b0;
         r_ex_rn    <= '0;
      end else if (!ext_stall) begin
         r_ex_a     <= w_op_a;
         r_ex_b     <= w_op_b;
         r_ex_aluc  <= id_aluc;
         r_ex_store <= w_fwd_rt;
         r_ex_valid <= 1'b1;
         r_ex_wreg  <= id_wreg;
         r_ex_m2reg <= id_m2reg;
         r_ex_wmem  <= id_wmem;
         r_ex_rn    <= id_rn;
      end
   end

   assign ex_a     = r_ex_a;
   assign ex_b     = r_ex_b;
   assign ex_aluc  = r_ex_aluc;
   assign ex_store = r_ex_store;
   assign ex_valid = r_ex_valid;
   assign ex_wreg  = r_ex_wreg;
   assign ex_m2reg = r_ex_m2reg;
   assign ex_wmem  = r_ex_wmem;
   assign ex_rn    = r_ex_rn;
   assign id_stall = w_id_stall;

endmodule
`default_nettype wire
